// File: rtl/sad_block_search.sv
`default_nettype none
// ============================================================================
// Module   : sad_block_search
// Purpose  : Streaming SAD engine with per-search minimum and index tracking.
// Revision : 1.0
// ============================================================================
module sad_block_search #(
  parameter  int WIDTH  = 8,
  parameter  int LANES  = 32,
  parameter  int BEATS  = 2,
  parameter  int CAND_W = 8,
  localparam int SAD_W  = WIDTH + $clog2(LANES * BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_start,
  input  logic                   in_end,
  input  logic [LANES*WIDTH-1:0] ori,
  input  logic [LANES*WIDTH-1:0] can,
  output logic [SAD_W-1:0]       sad,
  output logic [CAND_W-1:0]      sad_idx,
  output logic                   sad_valid,
  output logic [SAD_W-1:0]       best_sad,
  output logic [CAND_W-1:0]      best_idx,
  output logic                   best_valid
);

  localparam int BS_W = WIDTH + $clog2(LANES);
  localparam int BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  // S1: input capture
  logic [LANES*WIDTH-1:0] ori_q, can_q;
  logic                   v1_q, start1_q, end1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ori_q    <= '0;
      can_q    <= '0;
      v1_q     <= 1'b0;
      start1_q <= 1'b0;
      end1_q   <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        ori_q    <= ori;
        can_q    <= can;
        start1_q <= in_start;
        end1_q   <= in_end;
      end
    end
  end

  // S2: per-lane absolute difference and adder tree
  logic [WIDTH-1:0] w_absd [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] w_a, w_b;
    assign w_a = ori_q[gi*WIDTH +: WIDTH];
    assign w_b = can_q[gi*WIDTH +: WIDTH];
    assign w_absd[gi] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  end

  logic [BS_W-1:0] w_tree [LANES];
  logic [BS_W-1:0] w_beat_sum;

  // Pairwise reduction in place: after each level, slot i holds the sum of its 2*s subtree.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_tree[i] = BS_W'(w_absd[i]);
    end
    for (int s = 1; s < LANES; s = s * 2) begin
      for (int i = 0; i < LANES; i = i + 2 * s) begin
        w_tree[i] = w_tree[i] + w_tree[i+s];
      end
    end
    w_beat_sum = w_tree[0];
  end

  logic [BS_W-1:0] beat_sum_q;
  logic            v2_q, start2_q, end2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_sum_q <= '0;
      v2_q       <= 1'b0;
      start2_q   <= 1'b0;
      end2_q     <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        beat_sum_q <= w_beat_sum;
        start2_q   <= start1_q;
        end2_q     <= end1_q;
      end
    end
  end

  // S3: block accumulation and candidate numbering
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [SAD_W-1:0]  acc_q, acc_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic [SAD_W-1:0]  sad_q;
  logic [CAND_W-1:0] sad_idx_q;
  logic              sad_valid_q, sad_end_q;

  always_comb begin
    beat_d = start2_q ? '0 : beat_q;
    cand_d = start2_q ? '0 : cand_q;
    acc_d  = (beat_d == '0) ? SAD_W'(beat_sum_q) : acc_q + SAD_W'(beat_sum_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q      <= '0;
      acc_q       <= '0;
      cand_q      <= '0;
      sad_q       <= '0;
      sad_idx_q   <= '0;
      sad_valid_q <= 1'b0;
      sad_end_q   <= 1'b0;
    end else begin
      sad_valid_q <= 1'b0;
      if (v2_q) begin
        if (beat_d == LAST_BEAT) begin
          sad_q       <= acc_d;
          sad_idx_q   <= cand_d;
          sad_valid_q <= 1'b1;
          sad_end_q   <= end2_q;
          beat_q      <= '0;
          cand_q      <= end2_q ? '0 : cand_d + 1'b1;
        end else begin
          acc_q  <= acc_d;
          beat_q <= beat_d + 1'b1;
          cand_q <= cand_d;
        end
      end
    end
  end

  // S4: running minimum; strict compare keeps the earlier index on ties
  logic [SAD_W-1:0]  min_q, w_min_nxt;
  logic [CAND_W-1:0] min_idx_q, w_idx_nxt;
  logic              min_vld_q, w_take;
  logic [SAD_W-1:0]  best_sad_q;
  logic [CAND_W-1:0] best_idx_q;
  logic              best_valid_q;

  always_comb begin
    w_take    = !min_vld_q || (sad_q < min_q);
    w_min_nxt = w_take ? sad_q     : min_q;
    w_idx_nxt = w_take ? sad_idx_q : min_idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q        <= '0;
      min_idx_q    <= '0;
      min_vld_q    <= 1'b0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_valid_q <= 1'b0;
      if (sad_valid_q) begin
        if (sad_end_q) begin
          best_sad_q   <= w_min_nxt;
          best_idx_q   <= w_idx_nxt;
          best_valid_q <= 1'b1;
          min_vld_q    <= 1'b0;
        end else begin
          min_q     <= w_min_nxt;
          min_idx_q <= w_idx_nxt;
          min_vld_q <= 1'b1;
        end
      end
      // A restart entering S3 belongs to a new search, so it wins over any S4 update.
      if (v2_q && start2_q) begin
        min_vld_q <= 1'b0;
      end
    end
  end

  assign sad        = sad_q;
  assign sad_idx    = sad_idx_q;
  assign sad_valid  = sad_valid_q;
  assign best_sad   = best_sad_q;
  assign best_idx   = best_idx_q;
  assign best_valid = best_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sad_block_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_block_search
// Purpose  : Directed self-checking bench for sad_block_search.
// Revision : 1.0
// ============================================================================
module tb_sad_block_search;

  localparam int W  = 8;
  localparam int L  = 32;
  localparam int PB = L * W;
  localparam int SW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_start = 1'b0, in_end = 1'b0;
  logic [PB-1:0] ori = '0, can = '0;
  logic [SW-1:0] sad, best_sad;
  logic [7:0]    sad_idx, best_idx;
  logic          sad_valid, best_valid;
  logic [SW-1:0] sad2, best_sad2;
  logic [1:0]    sad_idx2, best_idx2;
  logic          sad_valid2, best_valid2;

  always #5 clk = ~clk;

  sad_block_search #(.WIDTH(8), .LANES(32), .BEATS(2), .CAND_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
    .ori(ori), .can(can), .sad(sad), .sad_idx(sad_idx), .sad_valid(sad_valid),
    .best_sad(best_sad), .best_idx(best_idx), .best_valid(best_valid));

  sad_block_search #(.WIDTH(8), .LANES(32), .BEATS(2), .CAND_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
    .ori(ori), .can(can), .sad(sad2), .sad_idx(sad_idx2), .sad_valid(sad_valid2),
    .best_sad(best_sad2), .best_idx(best_idx2), .best_valid(best_valid2));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { int cyc; int s; int i; } ev_t;
  ev_t sq[$];
  ev_t bq[$];
  int  iq2[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (sad_valid)  sq.push_back('{cyc, int'(sad), int'(sad_idx)});
    if (best_valid) bq.push_back('{cyc, int'(best_sad), int'(best_idx)});
    if (sad_valid2) iq2.push_back(int'(sad_idx2));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic en,
                       input logic [PB-1:0] o, input logic [PB-1:0] c);
    @(negedge clk);
    in_valid = v; in_start = st; in_end = en; ori = o; can = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [PB-1:0] pconst(input int v);
    logic [PB-1:0] p;
    for (int i = 0; i < L; i++) p[i*W +: W] = W'(v);
    return p;
  endfunction

  function automatic logic [PB-1:0] pramp(input int m);
    logic [PB-1:0] p;
    for (int i = 0; i < L; i++) p[i*W +: W] = W'(i * m);
    return p;
  endfunction

  // Spread a total across lanes (255 max each) so that against zeros the beat sum is t.
  function automatic logic [PB-1:0] pmk(input int t);
    logic [PB-1:0] p;
    int r, v;
    r = t;
    for (int i = 0; i < L; i++) begin
      v = (r > 255) ? 255 : r;
      p[i*W +: W] = W'(v);
      r = r - v;
    end
    return p;
  endfunction

  typedef struct {
    string         name;
    logic [PB-1:0] o0, c0, o1, c1;
    int            exp;
  } vec_t;

  vec_t tbl[5];
  ev_t  ev;
  int   lc, last_sad_cyc;
  int   vals[4];

  initial begin
    tbl[0] = '{"full_scale", pconst(255), pconst(0), pconst(255), pconst(0), 16320};
    tbl[1] = '{"ramp",       pramp(1),    pramp(2),  pramp(1),    pramp(2),  992};
    tbl[2] = '{"ramp_swap",  pramp(2),    pramp(1),  pramp(2),    pramp(1),  992};
    tbl[3] = '{"zero_diff",  pramp(3),    pramp(3),  pconst(77),  pconst(77), 0};
    tbl[4] = '{"mixed",      pconst(255), pconst(0), pramp(1),    pramp(2),  8656};

    // Reset state
    idle(3);
    chk("rst_sad", sad, 0);
    chk("rst_sad_idx", sad_idx, 0);
    chk("rst_sad_valid", sad_valid, 0);
    chk("rst_best_sad", best_sad, 0);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_best_valid", best_valid, 0);
    rst = 1'b1;
    idle(2);

    // Single-block vectors, each opening a fresh search
    for (int k = 0; k < 5; k++) begin
      sq.delete();
      drive(1'b1, 1'b1, 1'b0, tbl[k].o0, tbl[k].c0);
      drive(1'b1, 1'b0, 1'b0, tbl[k].o1, tbl[k].c1);
      lc = cyc;
      idle(6);
      chk({tbl[k].name, "_count"}, sq.size(), 1);
      if (sq.size() > 0) begin
        ev = sq.pop_front();
        chk({tbl[k].name, "_sad"}, ev.s, tbl[k].exp);
        chk({tbl[k].name, "_idx"}, ev.i, 0);
        chk({tbl[k].name, "_latency"}, ev.cyc - lc, 3);
      end
    end

    // Four-candidate search with a tie; earlier index must win
    sq.delete(); bq.delete();
    vals = '{500, 120, 120, 300};
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, j == 0, 1'b0, '0, pmk(vals[j]));
      drive(1'b1, 1'b0, j == 3, '0, '0);
    end
    idle(7);
    chk("search_count", sq.size(), 4);
    last_sad_cyc = 0;
    for (int j = 0; j < 4; j++) begin
      if (sq.size() > 0) begin
        ev = sq.pop_front();
        chk("search_sad", ev.s, vals[j]);
        chk("search_idx", ev.i, j);
        last_sad_cyc = ev.cyc;
      end
    end
    chk("best_count", bq.size(), 1);
    if (bq.size() > 0) begin
      ev = bq.pop_front();
      chk("best_sad", ev.s, 120);
      chk("best_idx", ev.i, 1);
      chk("best_latency", ev.cyc - last_sad_cyc, 1);
    end
    chk("best_sad_hold", best_sad, 120);
    chk("best_idx_hold", best_idx, 1);

    // After search end the next block is candidate 0
    drive(1'b1, 1'b0, 1'b0, '0, pmk(77));
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    idle(6);
    chk("post_end_count", sq.size(), 1);
    if (sq.size() > 0) begin
      ev = sq.pop_front();
      chk("post_end_sad", ev.s, 77);
      chk("post_end_idx", ev.i, 0);
    end

    // Abort a partial block with in_start, gaps between beats, in_end on beat 0 ignored
    sq.delete(); bq.delete();
    drive(1'b1, 1'b1, 1'b0, '0, pmk(400));
    idle(2);
    drive(1'b1, 1'b1, 1'b0, '0, pmk(200));
    idle($urandom_range(0, 3));
    drive(1'b1, 1'b0, 1'b0, '0, pmk(100));
    idle($urandom_range(0, 3));
    drive(1'b1, 1'b0, 1'b1, '0, pmk(50));
    idle($urandom_range(1, 4));
    drive(1'b1, 1'b0, 1'b0, '0, pmk(50));
    idle(7);
    chk("abort_count", sq.size(), 2);
    if (sq.size() > 1) begin
      ev = sq.pop_front();
      chk("abort_sad", ev.s, 300);
      chk("abort_idx", ev.i, 0);
      ev = sq.pop_front();
      chk("gap_sad", ev.s, 100);
      chk("gap_idx", ev.i, 1);
    end
    chk("nonfinal_end_best", bq.size(), 0);

    // Asynchronous reset between the two beats of a block
    sq.delete(); bq.delete();
    drive(1'b1, 1'b1, 1'b0, '0, pmk(60));
    idle(1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_sad", sad, 0);
    chk("arst_sad_idx", sad_idx, 0);
    chk("arst_best_sad", best_sad, 0);
    chk("arst_best_idx", best_idx, 0);
    chk("arst_valids", {sad_valid, best_valid}, 0);
    #1 rst = 1'b1;
    idle(6);
    chk("arst_no_pulse", sq.size() + bq.size(), 0);
    drive(1'b1, 1'b0, 1'b0, '0, pmk(70));
    idle(6);
    chk("arst_half_block", sq.size(), 0);
    drive(1'b1, 1'b0, 1'b0, '0, pmk(30));
    idle(6);
    chk("arst_full_count", sq.size(), 1);
    if (sq.size() > 0) begin
      ev = sq.pop_front();
      chk("arst_full_sad", ev.s, 100);
      chk("arst_full_idx", ev.i, 0);
    end

    // Candidate counter wrap with a 2-bit index
    iq2.delete();
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, j == 0, 1'b0, '0, pmk(10 + j));
      drive(1'b1, 1'b0, 1'b0, '0, '0);
    end
    idle(6);
    chk("wrap_count", iq2.size(), 5);
    for (int j = 0; j < 5; j++) begin
      if (iq2.size() > 0) chk("wrap_idx", iq2.pop_front(), j % 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
